// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural program counter plus the instruction-fetch
// sequencer of the multi-cycle CPU. Holds PC, fetches the word at PC over a
// req/ready handshake, latches it into IR and exposes PC / PC+4 / IR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        pc_misalign
);

  // S_RST only exists right after reset; S_REQ waits on memory; S_HOLD lets
  // the rest of the datapath execute the latched instruction.
  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        ir_valid_q;
  logic        misalign_q;
  logic        req_q;
  logic        busy_q;

  logic [31:0] pc_d;
  logic        misalign_d;
  logic        load_pc_s;

  // Candidate PC is always forced word aligned; low bits only raise a flag.
  always_comb begin
    pc_d       = {next_pc[31:2], 2'b00};
    misalign_d = |next_pc[1:0];
    load_pc_s  = 1'b0;
    if (pc_write && !stall) begin
      load_pc_s = 1'b1;
    end else begin
      load_pc_s = 1'b0;
    end
  end

  // Fetch sequencer: state, PC, IR and all handshake/pulse outputs.
  // Request and busy are flops cleared by the async reset, so they drop
  // immediately when rst_n falls, even in the middle of a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_RST: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_REQ: begin
          // PC is frozen here: pc_write and stall have no effect.
          if (imem_ready) begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
            state_q    <= S_HOLD;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            state_q    <= S_REQ;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_HOLD: begin
          // Stall beats pc_write; loading the same PC simply refetches it.
          if (load_pc_s) begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            state_q    <= S_REQ;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= S_HOLD;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RST;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign fetch_busy  = busy_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed stimulus pushes the expected
// (pc, instruction) of every fetch into a scoreboard; a negedge monitor pops
// and compares whenever ir_valid pulses. Direct probes cover PC/handshake.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic        ir_valid;
  logic        fetch_busy;
  logic        pc_misalign;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   cyc;
  int   last_valid_cyc;
  int   pushed;
  int   seen;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc    (next_pc),
    .pc_write   (pc_write),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .pc_misalign(pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between ir_valid pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every ir_valid pulse must match the next expected fetch.
  always @(negedge clk) begin
    if (ir_valid === 1'b1) begin
      seen = seen + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_ir_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ir", ir, e.ir);
        chk("sb_pc", pc, e.pc);
      end
      if (last_valid_cyc >= 0) begin
        chk("ir_valid_gap_ge2", 32'(((cyc - last_valid_cyc) >= 2) ? 1 : 0), 32'd1);
      end
      last_valid_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.pc = a;
    e.ir = d;
    exp_q.push_back(e);
    pushed = pushed + 1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_valid_cyc = -1; pushed = 0; seen = 0;
    rst_n = 1'b0; next_pc = 32'h0; pc_write = 1'b0; stall = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;

    // Reset state
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_misalign", 32'(pc_misalign), 32'd0);

    // Reset release: first fetch at address 0
    rst_n = 1'b1;
    expect_fetch(32'h0, 32'h2008_0005);
    tick();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_busy", 32'(fetch_busy), 32'd1);
    chk("rel_pc_plus4", pc_plus4, 32'h4);
    tick();
    chk("rel_ir_valid", 32'(ir_valid), 32'd1);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_busy", 32'(fetch_busy), 32'd0);
    tick();
    chk("rel_ir_valid_pulse", 32'(ir_valid), 32'd0);
    chk("hold_ir_kept", ir, 32'h2008_0005);

    // Wait states: refetch pc 0, memory not ready for 3 cycles
    imem_ready = 1'b0; pc_write = 1'b1; next_pc = 32'h0;
    tick();
    next_pc = 32'h0000_0040;   // pc_write stays high but must be ignored in S_REQ
    for (int i = 0; i < 4; i++) begin
      chk("ws_req", 32'(imem_req), 32'd1);
      chk("ws_addr", imem_addr, 32'h0);
      chk("ws_busy", 32'(fetch_busy), 32'd1);
      chk("ws_pc", pc, 32'h0);
      if (i == 3) begin
        imem_ready = 1'b1; imem_rdata = 32'hAC01_0000;
        expect_fetch(32'h0, 32'hAC01_0000);
      end
      tick();
      if (i < 3) chk("ws_no_valid", 32'(ir_valid), 32'd0);
    end
    pc_write = 1'b0;
    chk("ws_ir", ir, 32'hAC01_0000);
    chk("ws_done_req", 32'(imem_req), 32'd0);
    tick();

    // Sequential update 0 -> 4 -> 8
    pc_write = 1'b1; next_pc = 32'h4; imem_rdata = 32'h1111_0004;
    expect_fetch(32'h4, 32'h1111_0004);
    tick();
    chk("seq4_pc", pc, 32'h4);
    chk("seq4_addr", imem_addr, 32'h4);
    chk("seq4_req", 32'(imem_req), 32'd1);
    pc_write = 1'b0;
    tick();
    pc_write = 1'b1; next_pc = 32'h8; imem_rdata = 32'h2222_0008;
    expect_fetch(32'h8, 32'h2222_0008);
    tick();
    chk("seq8_pc", pc, 32'h8);
    pc_write = 1'b0;
    tick();

    // Stall priority over pc_write
    stall = 1'b1; pc_write = 1'b1; next_pc = 32'h0040_0010; imem_rdata = 32'h3333_0010;
    tick();
    chk("stall1_pc", pc, 32'h8);
    chk("stall1_req", 32'(imem_req), 32'd0);
    tick();
    chk("stall2_pc", pc, 32'h8);
    stall = 1'b0;
    expect_fetch(32'h0040_0010, 32'h3333_0010);
    tick();
    chk("unstall_pc", pc, 32'h0040_0010);
    chk("unstall_req", 32'(imem_req), 32'd1);
    pc_write = 1'b0;
    tick();

    // Misaligned target and wrap-around
    pc_write = 1'b1; next_pc = 32'h0000_1007; imem_rdata = 32'h4444_1004;
    expect_fetch(32'h0000_1004, 32'h4444_1004);
    tick();
    chk("mis_pc", pc, 32'h0000_1004);
    chk("mis_flag", 32'(pc_misalign), 32'd1);
    pc_write = 1'b0;
    tick();
    chk("mis_flag_pulse", 32'(pc_misalign), 32'd0);
    pc_write = 1'b1; next_pc = 32'hFFFF_FFFC; imem_rdata = 32'h5555_FFFC;
    expect_fetch(32'hFFFF_FFFC, 32'h5555_FFFC);
    tick();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    chk("wrap_no_misalign", 32'(pc_misalign), 32'd0);
    pc_write = 1'b0;
    tick();

    // Async reset in the middle of a fetch at 0x100
    pc_write = 1'b1; next_pc = 32'h0000_0100; imem_ready = 1'b0;
    tick();
    chk("mid_pc", pc, 32'h0000_0100);
    chk("mid_req", 32'(imem_req), 32'd1);
    pc_write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_busy", 32'(fetch_busy), 32'd0);
    chk("async_pc", pc, 32'h0);
    tick();
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h6666_0000;
    expect_fetch(32'h0, 32'h6666_0000);
    tick();
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    tick();
    tick();

    // Every expected fetch must have produced exactly one ir_valid pulse
    chk("sb_all_seen", 32'(seen), 32'(pushed));
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the multi-cycle CPU.
- Sits directly downstream of the next-PC select mux: consumes the selected 32-bit next address, holds the architectural PC, and fetches the instruction at PC over a req/ready handshake to instruction memory.
- Provides PC, PC+4 and the latched instruction register (IR) to decode, ALU and branch/jump target logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  32  selected next address from the next-PC mux.
- pc_write  input  1  control request to load next_pc into PC.
- stall  input  1  hold request from control; blocks PC update.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ready  input  1  memory accepts the request and returns data this cycle.
- imem_rdata  input  32  instruction word; valid when imem_req & imem_ready.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
- ir  output  32  latched instruction.
- ir_valid  output  1  one-cycle pulse when a new instruction is latched into ir.
- fetch_busy  output  1  high while a fetch is outstanding (state S_REQ).
- pc_misalign  output  1  one-cycle pulse when a loaded next_pc had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ir=0, ir_valid=0, pc_misalign=0, state=S_RST. imem_req and fetch_busy go 0 immediately, without waiting for a clock edge.
- States: S_RST, S_REQ, S_HOLD. All state, pc, ir and pulses are registered.
- S_RST:
  - Entered only by reset.
  - On the first clock edge with rst_n=1, go to S_REQ.
  - imem_req=0.
- S_REQ:
  - imem_req=1, fetch_busy=1.
  - imem_addr=pc, held stable until accepted.
  - If imem_ready=1 at the edge: ir<=imem_rdata, ir_valid<=1 for the next cycle only, go to S_HOLD.
  - Otherwise remain in S_REQ with no limit on wait cycles.
  - pc_write and stall are ignored in this state; pc does not change.
- S_HOLD:
  - imem_req=0, fetch_busy=0. ir is held.
  - If pc_write=1 and stall=0 at the edge: pc<={next_pc[31:2],2'b00}. pc_misalign<=1 for one cycle if next_pc[1:0]!=0. Go to S_REQ.
  - If stall=1: remain in S_HOLD and keep pc, regardless of pc_write. Stall wins over a simultaneous pc_write.
  - If pc_write=0: remain in S_HOLD. The instruction executes over multiple cycles.
- Latency:
  - pc_write accepted at edge N: new pc and imem_req=1 are visible after edge N.
  - With memory ready in the same cycle, ir_valid is high after edge N+1.
  - Minimum instruction period is 2 cycles (one S_REQ cycle, one S_HOLD cycle).
- Wrap-around: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000, with no flag.
- Reset mid-fetch: S_REQ is abandoned and imem_req drops asynchronously. After release, the fetch restarts at RESET_PC.
- pc_write=1 with next_pc equal to pc is legal and re-fetches the same address.

Test Plan:
- Reset release: RESET_PC=0, imem_ready tied 1, rdata=32'h2008_0005 -> imem_req high at addr 0 one cycle after release; next cycle ir=32'h2008_0005 and ir_valid pulses one cycle; pc_plus4=4.
- Wait states: imem_ready low 3 cycles then high with rdata=32'hAC01_0000 -> imem_req held with addr constant for 4 cycles, fetch_busy=1, pc_write pulses in S_REQ do not change pc; ir updates once.
- Sequential update: in S_HOLD with pc=0, pc_write=1, next_pc=4 -> pc=4 next cycle, fetch at 4; repeat with next_pc=8 -> ir_valid pulses spaced at least 2 cycles apart.
- Stall priority: S_HOLD with stall=1, pc_write=1, next_pc=32'h0040_0010 for 2 cycles -> pc unchanged; drop stall -> pc=32'h0040_0010 next cycle.
- Misalign and wrap: next_pc=32'h0000_1007 -> pc=32'h0000_1004 and pc_misalign pulses once; next_pc=32'hFFFF_FFFC -> pc_plus4=0.
- Async reset mid-fetch: assert rst_n=0 mid-cycle during S_REQ at addr 32'h0000_0100 -> imem_req=0 and pc=RESET_PC immediately; after release, the fetch restarts at RESET_PC.
